echo_event_rx: RTL and testbench
================================

Name: echo_event_rx

Overview:
- Receive end of the level-held echo voice bus {echo_on, echo_note, echo_vel, echo_pb} from the echo generator.
- The bus signals events only by value change. This block detects each change, classifies it, and queues it as a discrete event.
- Events are presented to the GB voice/channel driver over a valid/ready handshake.
- Isolates the channel driver from echo timing and makes back-to-back echo replays lossless up to DEPTH queued events.

Parameters:
- DEPTH, 8, event queue capacity including output register (power of 2, >=2)
- NOTE_W, 7, note and velocity width
- PB_W, 9, pitch-bend width

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- en  in  1  sample enable; inputs ignored when low
- echo_on  in  1  held gate level
- echo_note  in  NOTE_W  held note number
- echo_vel  in  NOTE_W  held velocity
- echo_pb  in  PB_W  held pitch bend
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event
- ev_type  out  2  0=NOTE_OFF, 1=NOTE_ON, 2=PB, 3=UPDATE
- ev_note  out  NOTE_W  event note
- ev_vel  out  NOTE_W  event velocity
- ev_pb  out  PB_W  event pitch bend
- ev_count  out  $clog2(DEPTH)+1  events held
- overflow  out  1  sticky: event dropped on full
- clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset_n=0 at posedge): shadow regs, ev_count, pointers and overflow all go to 0. ev_valid=0, ev_type=0, and all ev_* payloads=0.
- Shadow regs {on, note, vel, pb} hold the last sampled bus value.
- Change = en && ({inputs} != {shadow}). Detection is a combinational compare.
- On a change edge the shadow updates to the inputs, and exactly one event is generated carrying the new values.
- Classification, first match wins:
  - on 0->1 -> NOTE_ON
  - on 1->0 -> NOTE_OFF
  - on=1 and note changed -> NOTE_ON (retrigger)
  - only pb changed -> PB
  - otherwise -> UPDATE
- Latency: change sampled at edge N with queue empty -> ev_valid=1 after edge N (1 clk). Bypass goes straight to the output register.
- Non-empty queue: strict FIFO order, no reordering, no coalescing.
- Handshake: pop on posedge when ev_valid && ev_ready. While ev_valid && !ev_ready, all ev_* outputs hold stable. ev_valid never deasserts without a pop or reset.
- When ev_valid=0, payload outputs are 0.
- Full (ev_count==DEPTH):
  - Change with no pop that edge -> event dropped, overflow<=1, shadow still updates (no duplicate later).
  - Change with pop that edge -> both happen, count unchanged, no overflow.
- clr_overflow clears overflow. If set and clear coincide, set wins.
- en=0: no sampling, shadow held, no push; pops continue. On the first en=1 cycle, any difference from the shadow yields a single event with the current values.
- ev_count: +1 on push, -1 on pop, unchanged on push+pop. Range 0..DEPTH, never wraps. Pointers wrap modulo DEPTH.
- Reset mid-operation discards all queued events. Shadow returns to 0, so a nonzero held bus after release produces one event.

Decomposition:
- Package echo_pkg:
  - NOTE_W/PB_W constants
  - ev_type_t enum {EV_NOTE_OFF, EV_NOTE_ON, EV_PB, EV_UPDATE}
  - packed echo_ev_t {type, note, vel, pb}
- Sub-module echo_ev_fifo: generic show-ahead synchronous FIFO of echo_ev_t with bypass-to-output, count and full/empty.
- Top handles change detect, classify and overflow.

Test Plan:
- Reset: reset_n=0 for 2 clk with bus nonzero -> ev_valid=0, ev_count=0, overflow=0, payloads 0. Release with bus on=1/note=60/vel=50/pb=256 -> one NOTE_ON event after 1 clk.
- Basic flow, ev_ready=1: on 0->1, note 60, vel 50, pb 256 at edge N -> ev_valid=1 after N, type=1, 60/50/256, popped at N+1, count back to 0.
  - on 1->0 -> type=0.
  - pb 256->300 with on=1 -> type=2.
  - vel 50->40 only -> type=3.
  - note 60->64 with on=1 -> type=1.
- Backpressure, ev_ready=0: 9 distinct changes -> count=8, overflow=1. Release ready -> first 8 events delivered in order with payloads intact, 9th never appears. clr_overflow -> overflow=0.
- Full with simultaneous pop: count=8, change and pop on the same edge -> count stays 8, overflow stays 0, new event is last out.
- Enable gating: en=0 while bus steps through note 60->62->65 -> no events. en=1 -> exactly one event, note=65.
- Reset mid-queue: count=5, ready=0, pulse reset_n=0 for one edge -> next cycle ev_valid=0, count=0, overflow=0. Held nonzero bus -> one new event after release.

Source files
------------

// File: rtl/echo_pkg.sv
// Shared types for the echo voice-bus receiver: event encoding, payload
// widths and the change-classification rule.
package echo_pkg;

  localparam int NOTE_W = 7;
  localparam int PB_W   = 9;

  typedef enum logic [1:0] {
    EV_NOTE_OFF = 2'd0,
    EV_NOTE_ON  = 2'd1,
    EV_PB       = 2'd2,
    EV_UPDATE   = 2'd3
  } ev_type_t;

  typedef struct packed {
    ev_type_t            ev_type;
    logic [NOTE_W-1:0]   note;
    logic [NOTE_W-1:0]   vel;
    logic [PB_W-1:0]     pb;
  } echo_ev_t;

  // Gate edges take priority; a note change while held is a retrigger.
  function automatic ev_type_t classify(
    input logic              old_on,
    input logic              new_on,
    input logic [NOTE_W-1:0] old_note,
    input logic [NOTE_W-1:0] new_note,
    input logic [NOTE_W-1:0] old_vel,
    input logic [NOTE_W-1:0] new_vel,
    input logic [PB_W-1:0]   old_pb,
    input logic [PB_W-1:0]   new_pb
  );
    ev_type_t t;
    if (!old_on && new_on) begin
      t = EV_NOTE_ON;
    end else if (old_on && !new_on) begin
      t = EV_NOTE_OFF;
    end else if (new_on && (old_note != new_note)) begin
      t = EV_NOTE_ON;
    end else if ((old_pb != new_pb) && (old_note == new_note) && (old_vel == new_vel)) begin
      t = EV_PB;
    end else begin
      t = EV_UPDATE;
    end
    return t;
  endfunction

endpackage

// File: rtl/echo_ev_fifo.sv
// Show-ahead event FIFO whose head lives in a registered output stage; an
// event pushed into an otherwise empty queue bypasses storage for 1-clk latency.
module echo_ev_fifo
  import echo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  echo_ev_t                 push_data,
  input  logic                     pop_ready,
  output logic                     out_valid,
  output echo_ev_t                 out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  echo_ev_t        mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            valid_r;
  echo_ev_t        out_r;

  logic pop_s, full_s, push_ok_s, mem_empty_s, load_s, mem_rd_s, bypass_s, mem_wr_s;

  // Decide where this cycle's push lands and whether the head stage reloads.
  always_comb begin
    pop_s       = valid_r && pop_ready;
    full_s      = (count_r == CW'(DEPTH));
    push_ok_s   = push && (!full_s || pop_s);
    mem_empty_s = (count_r == {{(CW-1){1'b0}}, valid_r});
    load_s      = !valid_r || pop_s;
    mem_rd_s    = load_s && !mem_empty_s;
    bypass_s    = load_s && mem_empty_s && push_ok_s;
    mem_wr_s    = push_ok_s && !bypass_s;
  end

  // Storage array, no reset so it can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      out_r    <= '0;
    end else begin
      if (mem_wr_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (mem_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (load_s) begin
        if (mem_rd_s) begin
          out_r   <= mem_r[rd_ptr_r];
          valid_r <= 1'b1;
        end else if (bypass_s) begin
          out_r   <= push_data;
          valid_r <= 1'b1;
        end else begin
          out_r   <= '0;
          valid_r <= 1'b0;
        end
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign out_valid = valid_r;
  assign out_data  = out_r;
  assign count     = count_r;
  assign full      = full_s;
  assign empty     = (count_r == {CW{1'b0}});

endmodule

// File: rtl/echo_event_rx.sv
// Receive end of the level-held echo voice bus: turns value changes into
// classified discrete events queued behind a valid/ready interface.
module echo_event_rx #(
  parameter int DEPTH  = 8,
  parameter int NOTE_W = 7,
  parameter int PB_W   = 9
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     echo_on,
  input  logic [NOTE_W-1:0]        echo_note,
  input  logic [NOTE_W-1:0]        echo_vel,
  input  logic [PB_W-1:0]          echo_pb,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [1:0]               ev_type,
  output logic [NOTE_W-1:0]        ev_note,
  output logic [NOTE_W-1:0]        ev_vel,
  output logic [PB_W-1:0]          ev_pb,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  import echo_pkg::*;

  logic              shadow_on_r;
  logic [NOTE_W-1:0] shadow_note_r;
  logic [NOTE_W-1:0] shadow_vel_r;
  logic [PB_W-1:0]   shadow_pb_r;
  logic              overflow_r;

  logic     change_s, pop_s, drop_s, full_s, empty_s, out_valid_s;
  echo_ev_t new_ev_s, out_ev_s;

  // Change detect against the shadow and build the event it would produce.
  always_comb begin
    change_s = en && ({echo_on, echo_note, echo_vel, echo_pb} !=
                      {shadow_on_r, shadow_note_r, shadow_vel_r, shadow_pb_r});
    new_ev_s.ev_type = classify(shadow_on_r, echo_on, shadow_note_r, echo_note,
                                shadow_vel_r, echo_vel, shadow_pb_r, echo_pb);
    new_ev_s.note    = echo_note;
    new_ev_s.vel     = echo_vel;
    new_ev_s.pb      = echo_pb;
    pop_s            = !empty_s && ev_ready;
    drop_s           = change_s && full_s && !pop_s;
  end

  // Shadow follows the bus on every change, even when the event is dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_on_r   <= 1'b0;
      shadow_note_r <= {NOTE_W{1'b0}};
      shadow_vel_r  <= {NOTE_W{1'b0}};
      shadow_pb_r   <= {PB_W{1'b0}};
    end else if (change_s) begin
      shadow_on_r   <= echo_on;
      shadow_note_r <= echo_note;
      shadow_vel_r  <= echo_vel;
      shadow_pb_r   <= echo_pb;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end
  end

  echo_ev_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (change_s),
    .push_data (new_ev_s),
    .pop_ready (ev_ready),
    .out_valid (out_valid_s),
    .out_data  (out_ev_s),
    .count     (ev_count),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign ev_valid = out_valid_s;
  assign ev_type  = out_ev_s.ev_type;
  assign ev_note  = out_ev_s.note;
  assign ev_vel   = out_ev_s.vel;
  assign ev_pb    = out_ev_s.pb;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_echo_event_rx.sv
// Bench for echo_event_rx: directed scenarios plus random traffic, all checked
// every cycle against a queue-based event model.
module tb_echo_event_rx;

  localparam int DEPTH = 8;
  localparam int NW    = 7;
  localparam int PW    = 9;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n, en, echo_on, ev_ready, clr_overflow;
  logic [NW-1:0] echo_note, echo_vel;
  logic [PW-1:0] echo_pb;
  logic          ev_valid, overflow;
  logic [1:0]    ev_type;
  logic [NW-1:0] ev_note, ev_vel;
  logic [PW-1:0] ev_pb;
  logic [CW-1:0] ev_count;

  always #5 clk = ~clk;

  echo_event_rx #(.DEPTH(DEPTH), .NOTE_W(NW), .PB_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .echo_on(echo_on),
    .echo_note(echo_note), .echo_vel(echo_vel), .echo_pb(echo_pb),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_note(ev_note), .ev_vel(ev_vel), .ev_pb(ev_pb),
    .ev_count(ev_count), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  typedef struct {
    int t;
    int n;
    int v;
    int p;
  } mev_t;

  mev_t q[$];
  int   m_on, m_note, m_vel, m_pb;
  bit   m_ovf;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_bus(input int on, input int note, input int vel, input int pb);
    echo_on   = 1'(on);
    echo_note = NW'(note);
    echo_vel  = NW'(vel);
    echo_pb   = PW'(pb);
  endtask

  // Advance one clock: update the model from pre-edge inputs, then compare.
  task automatic tick();
    bit   pop, chg;
    mev_t e;
    if (!reset_n) begin
      q.delete();
      m_on = 0; m_note = 0; m_vel = 0; m_pb = 0;
      m_ovf = 1'b0;
    end else begin
      pop = (q.size() > 0) && ev_ready;
      chg = en && ((int'(echo_on) != m_on) || (int'(echo_note) != m_note) ||
                   (int'(echo_vel) != m_vel) || (int'(echo_pb) != m_pb));
      if (chg) begin
        if (m_on == 0 && echo_on) e.t = 1;
        else if (m_on == 1 && !echo_on) e.t = 0;
        else if (echo_on && int'(echo_note) != m_note) e.t = 1;
        else if (int'(echo_note) == m_note && int'(echo_vel) == m_vel) e.t = 2;
        else e.t = 3;
        e.n = int'(echo_note); e.v = int'(echo_vel); e.p = int'(echo_pb);
        m_on = int'(echo_on); m_note = e.n; m_vel = e.v; m_pb = e.p;
      end
      if (pop) void'(q.pop_front());
      if (chg && q.size() < DEPTH) q.push_back(e);
      if (chg && q.size() >= DEPTH && !pop && !(q.size() > 0 && q[$] == e)) m_ovf = 1'b1;
      else if (clr_overflow && !(chg && !pop && q.size() == DEPTH && q[$] != e)) m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("ev_valid", int'(ev_valid), (q.size() > 0) ? 1 : 0);
    chk("ev_count", int'(ev_count), q.size());
    chk("overflow", int'(overflow), int'(m_ovf));
    if (q.size() > 0) begin
      chk("ev_type", int'(ev_type), q[0].t);
      chk("ev_note", int'(ev_note), q[0].n);
      chk("ev_vel",  int'(ev_vel),  q[0].v);
      chk("ev_pb",   int'(ev_pb),   q[0].p);
    end else begin
      chk("ev_payload_zero", int'({ev_type, ev_note, ev_vel, ev_pb}), 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; ev_ready = 1'b1; clr_overflow = 1'b0;
    set_bus(1, 60, 50, 256);
    tick();
    tick();
    chk("reset_valid", int'(ev_valid), 0);
    chk("reset_count", int'(ev_count), 0);
    chk("reset_ovf",   int'(overflow), 0);

    // Release with the bus held: one NOTE_ON after one clock, then popped.
    reset_n = 1'b1;
    tick();
    chk("rel_type", int'(ev_type), 1);
    chk("rel_note", int'(ev_note), 60);
    chk("rel_pb",   int'(ev_pb),   256);
    tick();
    chk("rel_popped", int'(ev_count), 0);

    // Basic classification with ready held high.
    set_bus(0, 60, 50, 256); tick(); chk("off_type", int'(ev_type), 0); tick();
    set_bus(1, 60, 50, 256); tick(); chk("on_type",  int'(ev_type), 1); tick();
    set_bus(1, 60, 50, 300); tick(); chk("pb_type",  int'(ev_type), 2); tick();
    set_bus(1, 60, 40, 300); tick(); chk("upd_type", int'(ev_type), 3); tick();
    set_bus(1, 64, 40, 300); tick(); chk("retrig_type", int'(ev_type), 1); tick();

    // Backpressure: nine changes into an eight-deep queue.
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_bus(1, 10 + i, 40, 300);
      tick();
    end
    chk("bp_count", int'(ev_count), 8);
    chk("bp_ovf",   int'(overflow), 1);
    chk("bp_head",  int'(ev_note),  10);
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_drained", int'(ev_valid), 0);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("bp_clr", int'(overflow), 0);

    // Full queue with a change and a pop on the same edge.
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_bus(1, 20 + i, 40, 300);
      tick();
    end
    set_bus(1, 99, 40, 300); ev_ready = 1'b1;
    tick();
    chk("fp_count", int'(ev_count), 8);
    chk("fp_ovf",   int'(overflow), 0);
    for (int i = 0; i < 7; i++) tick();
    chk("fp_last", int'(ev_note), 99);
    tick();

    // Enable gating: steps while disabled collapse into one event.
    en = 1'b0;
    set_bus(1, 62, 40, 300); tick();
    set_bus(1, 65, 40, 300); tick();
    chk("en_none", int'(ev_valid), 0);
    en = 1'b1; tick();
    chk("en_note", int'(ev_note), 65);
    tick();
    chk("en_single", int'(ev_valid), 0);

    // Reset with five events queued.
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_bus(1, 30 + i, 40, 300);
      tick();
    end
    chk("rm_count", int'(ev_count), 5);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk("rm_valid", int'(ev_valid), 0);
    chk("rm_cnt0",  int'(ev_count), 0);
    tick();
    chk("rm_new", int'(ev_note), 34);
    ev_ready = 1'b1; tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      en           = ($urandom_range(9) != 0);
      ev_ready     = ($urandom_range(2) != 0);
      clr_overflow = ($urandom_range(15) == 0);
      reset_n      = ($urandom_range(499) != 0);
      if ($urandom_range(2) == 0) echo_on   = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) echo_note = NW'(60 + 2 * $urandom_range(2));
      if ($urandom_range(3) == 0) echo_vel  = NW'($urandom_range(127));
      if ($urandom_range(3) == 0) echo_pb   = PW'($urandom_range(511));
      tick();
    end
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
